// File: rtl/lapido_pkg.sv
// Shared definitions for the Lapido EX stage: widths, forwarding-select codes
// and the 5-bit ALU opcode enumeration.
package lapido_pkg;

    localparam int DW = 32;
    localparam int RW = 4;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef enum logic [4:0] {
        ALU_ADD      = 5'h00,
        ALU_ADDINC   = 5'h01,
        ALU_INCA     = 5'h02,
        ALU_SUB      = 5'h03,
        ALU_SUBDEC   = 5'h04,
        ALU_DECA     = 5'h05,
        ALU_LSL      = 5'h06,
        ALU_LSR      = 5'h07,
        ALU_ASR      = 5'h08,
        ALU_ASL      = 5'h09,
        ALU_ZEROS    = 5'h0A,
        ALU_ONES     = 5'h0B,
        ALU_PASSA    = 5'h0C,
        ALU_PASSNOTA = 5'h0D,
        ALU_AND      = 5'h0E,
        ALU_OR       = 5'h0F,
        ALU_XOR      = 5'h10,
        ALU_NAND     = 5'h11,
        ALU_NOR      = 5'h12,
        ALU_XNOR     = 5'h13,
        ALU_ANDNOTA  = 5'h14,
        ALU_ORNOTB   = 5'h15,
        ALU_PASSB    = 5'h16
    } alu_op_e;

endpackage

// File: rtl/ex_alu_core.sv
// Purely combinational ALU with zero/carry/overflow/neg flag generation.
module ex_alu_core
    import lapido_pkg::*;
#(
    parameter int DW = lapido_pkg::DW
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [4:0]    i_op,
    output logic [DW-1:0] o_result,
    output logic          o_zero,
    output logic          o_carry,
    output logic          o_overflow,
    output logic          o_neg
);

    alu_op_e       w_op;
    logic [DW-1:0] w_y;
    logic          w_cin;
    logic          w_is_sub;
    logic [DW:0]   w_sum;

    assign w_op = alu_op_e'(i_op);

    // Every add/subtract variant maps onto one adder: A + y + cin, where a
    // subtract inverts y and reports borrow as the complement of carry-out.
    always_comb begin
        w_y      = i_b;
        w_cin    = 1'b0;
        w_is_sub = 1'b0;
        case (w_op)
            ALU_ADDINC: w_cin = 1'b1;
            ALU_INCA:   begin w_y = '0;    w_cin = 1'b1; end
            ALU_SUB:    begin w_y = ~i_b;  w_cin = 1'b1; w_is_sub = 1'b1; end
            ALU_SUBDEC: begin w_y = ~i_b;  w_is_sub = 1'b1; end
            ALU_DECA:   begin w_y = '1;    w_is_sub = 1'b1; end
            default:    ;
        endcase
    end

    assign w_sum = {1'b0, i_a} + {1'b0, w_y} + {{DW{1'b0}}, w_cin};

    always_comb begin
        o_result   = '0;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        case (w_op)
            ALU_ADD, ALU_ADDINC, ALU_INCA, ALU_SUB, ALU_SUBDEC, ALU_DECA: begin
                o_result   = w_sum[DW-1:0];
                o_carry    = w_sum[DW] ^ w_is_sub;
                o_overflow = (i_a[DW-1] == w_y[DW-1]) && (w_sum[DW-1] != i_a[DW-1]);
            end
            ALU_LSL, ALU_ASL: begin
                o_result = {i_a[DW-2:0], 1'b0};
                o_carry  = i_a[DW-1];
            end
            ALU_LSR: begin
                o_result = {1'b0, i_a[DW-1:1]};
                o_carry  = i_a[0];
            end
            ALU_ASR: begin
                o_result = {i_a[DW-1], i_a[DW-1:1]};
                o_carry  = i_a[0];
            end
            ALU_ZEROS:    o_result = '0;
            ALU_ONES:     o_result = '1;
            ALU_PASSA:    o_result = i_a;
            ALU_PASSNOTA: o_result = ~i_a;
            ALU_AND:      o_result = i_a & i_b;
            ALU_OR:       o_result = i_a | i_b;
            ALU_XOR:      o_result = i_a ^ i_b;
            ALU_NAND:     o_result = ~(i_a & i_b);
            ALU_NOR:      o_result = ~(i_a | i_b);
            ALU_XNOR:     o_result = ~(i_a ^ i_b);
            ALU_ANDNOTA:  o_result = ~i_a & i_b;
            ALU_ORNOTB:   o_result = i_a | ~i_b;
            ALU_PASSB:    o_result = i_b;
            default:      ;
        endcase
    end

    assign o_zero = (o_result == '0);
    assign o_neg  = o_result[DW-1];

endmodule

// File: rtl/ex_hazard_alu.sv
// EX stage: operand forwarding, load-use/branch hazard requests and the ALU.
// Define EX_FLAGS_REG_EN to register the four ALU flags on the rising clock.
module ex_hazard_alu
    import lapido_pkg::*;
#(
    parameter int DW = lapido_pkg::DW,
    parameter int RW = lapido_pkg::RW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [DW-1:0] i_id_ex_data_a,
    input  logic [DW-1:0] i_id_ex_data_b,
    input  logic [DW-1:0] i_wb_data,
    input  logic [DW-1:0] i_ex_mem_result,
    input  logic [RW-1:0] i_id_ex_reg_a,
    input  logic [RW-1:0] i_id_ex_reg_b,
    input  logic [RW-1:0] i_ex_mem_rd,
    input  logic [RW-1:0] i_mem_wb_rd,
    input  logic          i_ex_mem_regwrite,
    input  logic          i_mem_wb_regwrite,
    input  logic          i_id_ex_memread,
    input  logic [RW-1:0] i_id_ex_rd,
    input  logic [RW-1:0] i_if_id_reg_a,
    input  logic [RW-1:0] i_if_id_reg_b,
    input  logic          i_branch_taken,
    input  logic [4:0]    i_alu_op,
    output logic [DW-1:0] o_alu_out,
    output logic          o_zero,
    output logic          o_carry,
    output logic          o_overflow,
    output logic          o_neg,
    output logic [1:0]    o_forward_a,
    output logic [1:0]    o_forward_b,
    output logic          o_enable_pc,
    output logic          o_ctrl_bubble
);

    logic [DW-1:0] w_op_a;
    logic [DW-1:0] w_op_b;
    logic          w_load_use;
    logic          w_zero, w_carry, w_overflow, w_neg;

    // The younger producer (EX/MEM) wins when both stages write the same id.
    always_comb begin
        o_forward_a = FWD_IDEX;
        if (i_ex_mem_regwrite && (i_ex_mem_rd == i_id_ex_reg_a))
            o_forward_a = FWD_EXMEM;
        else if (i_mem_wb_regwrite && (i_mem_wb_rd == i_id_ex_reg_a))
            o_forward_a = FWD_MEMWB;

        o_forward_b = FWD_IDEX;
        if (i_ex_mem_regwrite && (i_ex_mem_rd == i_id_ex_reg_b))
            o_forward_b = FWD_EXMEM;
        else if (i_mem_wb_regwrite && (i_mem_wb_rd == i_id_ex_reg_b))
            o_forward_b = FWD_MEMWB;
    end

    always_comb begin
        case (o_forward_a)
            FWD_EXMEM: w_op_a = i_ex_mem_result;
            FWD_MEMWB: w_op_a = i_wb_data;
            default:   w_op_a = i_id_ex_data_a;
        endcase
        case (o_forward_b)
            FWD_EXMEM: w_op_b = i_ex_mem_result;
            FWD_MEMWB: w_op_b = i_wb_data;
            default:   w_op_b = i_id_ex_data_b;
        endcase
    end

    assign w_load_use    = i_id_ex_memread &&
                           ((i_id_ex_rd == i_if_id_reg_a) || (i_id_ex_rd == i_if_id_reg_b));
    assign o_enable_pc   = !w_load_use;
    assign o_ctrl_bubble = w_load_use || i_branch_taken;

    ex_alu_core #(.DW(DW)) u_alu (
        .i_a        (w_op_a),
        .i_b        (w_op_b),
        .i_op       (i_alu_op),
        .o_result   (o_alu_out),
        .o_zero     (w_zero),
        .o_carry    (w_carry),
        .o_overflow (w_overflow),
        .o_neg      (w_neg)
    );

`ifdef EX_FLAGS_REG_EN
    // Flags lag alu_out by one cycle; branch resolution upstream uses this zero.
    logic [3:0] r_flags;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_flags <= '0;
        else          r_flags <= {w_zero, w_carry, w_overflow, w_neg};
    end

    assign {o_zero, o_carry, o_overflow, o_neg} = r_flags;
`else
    logic w_unused_clk_rst;

    assign w_unused_clk_rst = i_clk ^ i_rst_n;
    assign {o_zero, o_carry, o_overflow, o_neg} = {w_zero, w_carry, w_overflow, w_neg};
`endif

endmodule

// File: tb/tb_ex_hazard_alu.sv
// Directed self-checking bench for ex_hazard_alu (both EX_FLAGS_REG_EN builds).
module tb_ex_hazard_alu;
    import lapido_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] id_ex_data_a = '0, id_ex_data_b = '0, wb_data = '0, ex_mem_result = '0;
    logic [3:0]  id_ex_reg_a = '0, id_ex_reg_b = '0, ex_mem_rd = '0, mem_wb_rd = '0;
    logic        ex_mem_regwrite = 1'b0, mem_wb_regwrite = 1'b0, id_ex_memread = 1'b0;
    logic [3:0]  id_ex_rd = '0, if_id_reg_a = '0, if_id_reg_b = '0;
    logic        branch_taken = 1'b0;
    logic [4:0]  alu_op = 5'h00;
    logic [31:0] alu_out;
    logic        zero, carry, overflow, neg;
    logic [1:0]  forward_a, forward_b;
    logic        enable_pc, ctrl_bubble;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_hazard_alu dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_ex_data_a(id_ex_data_a), .i_id_ex_data_b(id_ex_data_b),
        .i_wb_data(wb_data), .i_ex_mem_result(ex_mem_result),
        .i_id_ex_reg_a(id_ex_reg_a), .i_id_ex_reg_b(id_ex_reg_b),
        .i_ex_mem_rd(ex_mem_rd), .i_mem_wb_rd(mem_wb_rd),
        .i_ex_mem_regwrite(ex_mem_regwrite), .i_mem_wb_regwrite(mem_wb_regwrite),
        .i_id_ex_memread(id_ex_memread), .i_id_ex_rd(id_ex_rd),
        .i_if_id_reg_a(if_id_reg_a), .i_if_id_reg_b(if_id_reg_b),
        .i_branch_taken(branch_taken), .i_alu_op(alu_op),
        .o_alu_out(alu_out), .o_zero(zero), .o_carry(carry),
        .o_overflow(overflow), .o_neg(neg),
        .o_forward_a(forward_a), .o_forward_b(forward_b),
        .o_enable_pc(enable_pc), .o_ctrl_bubble(ctrl_bubble)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Flags packed as {zero,carry,overflow,neg}; with registered flags they
    // are checked just after the next rising edge.
    task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input logic [3:0] zcvn);
        alu_op = op; id_ex_data_a = a; id_ex_data_b = b;
        #1;
        chk(tag, alu_out, exp);
`ifdef EX_FLAGS_REG_EN
        @(posedge clk); #1;
`endif
        chk({tag, "_flags"}, {28'b0, zero, carry, overflow, neg}, {28'b0, zcvn});
    endtask

    initial begin
        // Reset: combinational paths stay live, flag register is cleared.
        #2;
        chk("rst_fwd_a", {30'b0, forward_a}, 32'h0);
        chk("rst_enable_pc", {31'b0, enable_pc}, 32'h1);
        chk("rst_bubble", {31'b0, ctrl_bubble}, 32'h0);
`ifdef EX_FLAGS_REG_EN
        chk("rst_flags", {28'b0, zero, carry, overflow, neg}, 32'h0);
`else
        chk("rst_zero_comb", {31'b0, zero}, 32'h1);
`endif
        #20 rst_n = 1'b1;
        @(negedge clk);

        // Forwarding: EX/MEM priority over MEM/WB on the same id.
        id_ex_data_a = 32'h3333_3333; id_ex_data_b = 32'h4444_4444;
        ex_mem_result = 32'h1111_0000; wb_data = 32'h2222_0000;
        ex_mem_regwrite = 1'b1; ex_mem_rd = 4'd3;
        mem_wb_regwrite = 1'b1; mem_wb_rd = 4'd3;
        id_ex_reg_a = 4'd3; id_ex_reg_b = 4'd7; alu_op = ALU_PASSA;
        #1;
        chk("fwd_a_exmem", {30'b0, forward_a}, 32'h2);
        chk("opA_exmem", alu_out, 32'h1111_0000);
        chk("fwd_b_none", {30'b0, forward_b}, 32'h0);
        alu_op = ALU_PASSB; #1;
        chk("opB_idex", alu_out, 32'h4444_4444);

        ex_mem_regwrite = 1'b0; alu_op = ALU_PASSA; #1;
        chk("fwd_a_memwb", {30'b0, forward_a}, 32'h1);
        chk("opA_memwb", alu_out, 32'h2222_0000);

        ex_mem_regwrite = 1'b1; ex_mem_rd = 4'd0; id_ex_reg_b = 4'd0; alu_op = ALU_PASSB; #1;
        chk("fwd_b_r0", {30'b0, forward_b}, 32'h2);
        chk("opB_r0", alu_out, 32'h1111_0000);

        mem_wb_regwrite = 1'b0; ex_mem_rd = 4'd9; #1;
        chk("fwd_b_mismatch", {30'b0, forward_b}, 32'h0);
        mem_wb_regwrite = 1'b1; mem_wb_rd = 4'd0; ex_mem_regwrite = 1'b0; #1;
        chk("fwd_b_memwb", {30'b0, forward_b}, 32'h1);
        chk("opB_memwb", alu_out, 32'h2222_0000);
        ex_mem_regwrite = 1'b0; mem_wb_regwrite = 1'b0; #1;
        chk("fwd_a_off", {30'b0, forward_a}, 32'h0);

        // Hazards.
        id_ex_memread = 1'b1; id_ex_rd = 4'd5; if_id_reg_a = 4'd1; if_id_reg_b = 4'd5; #1;
        chk("lu_enable_pc", {31'b0, enable_pc}, 32'h0);
        chk("lu_bubble", {31'b0, ctrl_bubble}, 32'h1);
        id_ex_rd = 4'd6; #1;
        chk("nolu_enable_pc", {31'b0, enable_pc}, 32'h1);
        chk("nolu_bubble", {31'b0, ctrl_bubble}, 32'h0);
        if_id_reg_a = 4'd6; id_ex_memread = 1'b0; #1;
        chk("lu_no_memread", {31'b0, enable_pc}, 32'h1);
        branch_taken = 1'b1; #1;
        chk("br_enable_pc", {31'b0, enable_pc}, 32'h1);
        chk("br_bubble", {31'b0, ctrl_bubble}, 32'h1);
        id_ex_memread = 1'b1; #1;
        chk("both_enable_pc", {31'b0, enable_pc}, 32'h0);
        chk("both_bubble", {31'b0, ctrl_bubble}, 32'h1);
        id_ex_memread = 1'b0; branch_taken = 1'b0;

        // ALU vectors: expected {zero,carry,overflow,neg}.
        alu("add_ovf",   ALU_ADD,      32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b0011);
        alu("add_carry", ALU_ADD,      32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1100);
        alu("addinc",    ALU_ADDINC,   32'h5,         32'h6,         32'hC,         4'b0000);
        alu("inca_ovf",  ALU_INCA,     32'h7FFF_FFFF, 32'h0,         32'h8000_0000, 4'b0011);
        alu("sub_borrow",ALU_SUB,      32'h2,         32'h3,         32'hFFFF_FFFF, 4'b0101);
        alu("sub_pos",   ALU_SUB,      32'h5,         32'h3,         32'h2,         4'b0000);
        alu("sub_ovf",   ALU_SUB,      32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 4'b0010);
        alu("subdec",    ALU_SUBDEC,   32'h5,         32'h5,         32'hFFFF_FFFF, 4'b0101);
        alu("deca_zero", ALU_DECA,     32'h0,         32'h0,         32'hFFFF_FFFF, 4'b0101);
        alu("deca_ovf",  ALU_DECA,     32'h8000_0000, 32'h0,         32'h7FFF_FFFF, 4'b0010);
        alu("lsl",       ALU_LSL,      32'h8000_0001, 32'h0,         32'h2,         4'b0100);
        alu("asl",       ALU_ASL,      32'h4000_0000, 32'h0,         32'h8000_0000, 4'b0001);
        alu("lsr",       ALU_LSR,      32'h8000_0003, 32'h0,         32'h4000_0001, 4'b0100);
        alu("asr",       ALU_ASR,      32'h8000_0001, 32'h0,         32'hC000_0000, 4'b0101);
        alu("zeros",     ALU_ZEROS,    32'h1234_5678, 32'h1,         32'h0,         4'b1000);
        alu("ones",      ALU_ONES,     32'h0,         32'h0,         32'hFFFF_FFFF, 4'b0001);
        alu("passnota",  ALU_PASSNOTA, 32'hF0F0_00FF, 32'h0,         32'h0F0F_FF00, 4'b0000);
        alu("and",       ALU_AND,      32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 4'b0000);
        alu("or",        ALU_OR,       32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 4'b0001);
        alu("xor",       ALU_XOR,      32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 4'b0001);
        alu("nand",      ALU_NAND,     32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF0F_FFF0, 4'b0001);
        alu("nor",       ALU_NOR,      32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h000F_F000, 4'b0000);
        alu("xnor",      ALU_XNOR,     32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00FF_F00F, 4'b0000);
        alu("andnota",   ALU_ANDNOTA,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0F00_0F00, 4'b0000);
        alu("ornotb",    ALU_ORNOTB,   32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hF0FF_F0FF, 4'b0001);
        alu("passb",     ALU_PASSB,    32'h0,         32'h8765_4321, 32'h8765_4321, 4'b0001);
        alu("undef_17",  5'h17,        32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1000);
        alu("undef_1f",  5'h1F,        32'h7FFF_FFFF, 32'h1,         32'h0,         4'b1000);

`ifdef EX_FLAGS_REG_EN
        // Flags set, then async reset clears them without a clock edge.
        alu("pre_rst",   ALU_ADD,      32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1100);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("midrst_flags", {28'b0, zero, carry, overflow, neg}, 32'h0);
        #3 rst_n = 1'b1;
        alu_op = ALU_ADD; id_ex_data_a = 32'h7FFF_FFFF; id_ex_data_b = 32'h1; #1;
        chk("postrst_hold", {28'b0, zero, carry, overflow, neg}, 32'h0);
        @(posedge clk); #1;
        chk("postrst_flags", {28'b0, zero, carry, overflow, neg}, 32'h3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
